// File: rtl/mem_bus_responder_pkg.sv
// Shared bus-geometry constants, FSM state and bus-command types for the
// coherent-bus memory responder.
package CachePackage;

  localparam int ADDRESSWIDTH = 16;
  localparam int DATABUSWIDTH = 32;
  localparam int BLOCKBYTES   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_WBACK,
    S_UPD,
    S_ABORT
  } mem_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RD,
    CMD_UPD,
    CMD_WB
  } bus_cmd_t;

  // Write-back beats update, which beats read; losers are simply dropped.
  function automatic bus_cmd_t decode_cmd(input logic rd, input logic upd, input logic wb);
    if (wb)  return CMD_WB;
    if (upd) return CMD_UPD;
    if (rd)  return CMD_RD;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_responder_mem_array.sv
// Single-port word memory with synchronous write and a registered read port,
// so read data lands one cycle after its address is presented.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = CachePackage::DATABUSWIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: storage arrays get no reset; contents must survive a bus reset and a
  // reset loop over every word would not map onto a RAM macro.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on a snooping coherent bus: block reads with
// critical-word-first wrap, block write-backs, single-word updates.
module mem_bus_responder #(
  parameter int ADDRESSWIDTH = CachePackage::ADDRESSWIDTH,
  parameter int DATABUSWIDTH = CachePackage::DATABUSWIDTH,
  parameter int BEATS        = CachePackage::BLOCKBYTES * 8 / CachePackage::DATABUSWIDTH,
  parameter int LATENCY      = 2,
  parameter int NSNOOP       = 3,
  parameter int MEMDEPTH     = 2 ** (ADDRESSWIDTH - 2)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    bus_rd,
  input  logic                    bus_upd,
  input  logic                    bus_wb,
  input  logic [ADDRESSWIDTH-1:0] bus_addr,
  input  logic [DATABUSWIDTH-1:0] bus_wdata,
  input  logic [NSNOOP-1:0]       snoop_shared,
  input  logic [NSNOOP-1:0]       snoop_flush,
  output logic                    busy,
  output logic [DATABUSWIDTH-1:0] rdata,
  output logic                    rvalid,
  output logic                    shared,
  output logic                    done,
  output logic                    err
);

  import CachePackage::*;

  localparam int BYTE_OFF = $clog2(DATABUSWIDTH / 8);
  localparam int IDXW     = ADDRESSWIDTH - BYTE_OFF;
  localparam int BOFF     = $clog2(BEATS);
  localparam int BLKW     = IDXW - BOFF;
  localparam int MAW      = $clog2(MEMDEPTH);
  localparam int CNT_W    = $clog2(LATENCY + BEATS) + 1;

  mem_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BLKW-1:0]   r_blk, w_blk_nxt;
  logic [BOFF-1:0]   r_start, w_start_nxt;
  logic              r_shared, w_shared_nxt;
  logic              r_err, w_err_nxt;

  bus_cmd_t          w_cmd;
  logic [IDXW-1:0]   w_idx;
  logic              w_oob;
  logic              w_flush;
  logic              w_lat_last;
  logic              w_beat_last;
  logic [BOFF-1:0]   w_rd_beat;
  logic [BOFF-1:0]   w_rd_off;
  logic              w_mem_we;
  logic [IDXW-1:0]   w_mem_idx;
  logic [DATABUSWIDTH-1:0] w_mem_rdata;

  assign w_cmd       = decode_cmd(bus_rd, bus_upd, bus_wb);
  assign w_idx       = bus_addr[ADDRESSWIDTH-1:BYTE_OFF];
  assign w_oob       = ({1'b0, w_idx} >= (IDXW + 1)'(MEMDEPTH));
  assign w_flush     = |snoop_flush;
  assign w_lat_last  = (r_cnt == CNT_W'(LATENCY - 1));
  assign w_beat_last = (r_cnt == CNT_W'(BEATS - 1));

  // The read port is registered, so the address runs one beat ahead of rvalid:
  // the last WAIT cycle fetches beat 0, beat k fetches beat k+1.
  assign w_rd_beat = (r_state == S_BURST) ? (r_cnt[BOFF-1:0] + BOFF'(1)) : '0;
  assign w_rd_off  = r_start + w_rd_beat;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_blk    <= '0;
      r_start  <= '0;
      r_shared <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_blk    <= w_blk_nxt;
      r_start  <= w_start_nxt;
      r_shared <= w_shared_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_blk_nxt    = r_blk;
    w_start_nxt  = r_start;
    w_shared_nxt = r_shared;
    w_err_nxt    = r_err;
    w_mem_we     = 1'b0;
    w_mem_idx    = {r_blk, w_rd_off};
    busy         = 1'b0;
    rvalid       = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cmd != CMD_NONE) begin
          w_blk_nxt   = w_idx[IDXW-1:BOFF];
          w_start_nxt = w_idx[BOFF-1:0];
          w_cnt_nxt   = '0;
          if (w_oob) begin
            // Out-of-range requests touch nothing and finish through ABORT.
            w_state_nxt = S_ABORT;
            w_err_nxt   = 1'b1;
          end else begin
            case (w_cmd)
              CMD_WB: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = {w_idx[IDXW-1:BOFF], {BOFF{1'b0}}};
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = S_WBACK;
              end
              CMD_UPD: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = w_idx;
                w_state_nxt = S_UPD;
              end
              CMD_RD: begin
                w_shared_nxt = (|snoop_shared) | w_flush;
                w_state_nxt  = w_flush ? S_ABORT : S_WAIT;
              end
              default: ;
            endcase
          end
        end
      end

      S_WAIT: begin
        busy = 1'b1;
        if (w_flush) begin
          // A cache will supply the block; memory stands down.
          w_shared_nxt = 1'b1;
          w_state_nxt  = S_ABORT;
        end else if (w_lat_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_BURST: begin
        busy   = 1'b1;
        rvalid = 1'b1;
        if (w_beat_last) begin
          done         = 1'b1;
          w_cnt_nxt    = '0;
          w_shared_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_WBACK: begin
        busy      = 1'b1;
        w_mem_we  = 1'b1;
        w_mem_idx = {r_blk, r_cnt[BOFF-1:0]};
        if (w_beat_last) begin
          done        = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_UPD: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_shared_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end

      S_ABORT: begin
        busy         = 1'b1;
        done         = 1'b1;
        err          = r_err;
        w_shared_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_state_nxt  = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign shared = r_shared;
  assign rdata  = rvalid ? w_mem_rdata : '0;

  mem_array #(
    .DEPTH (MEMDEPTH),
    .WIDTH (DATABUSWIDTH),
    .AW    (MAW)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_idx[MAW-1:0]),
    .i_wdata (bus_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Byte-lane bits and index bits above the memory depth carry no storage.
  if (IDXW > MAW) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_mem_idx[IDXW-1:MAW];
  end
  if (BYTE_OFF > 0) begin : g_unused_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^bus_addr[BYTE_OFF-1:0];
  end

endmodule
